// File: rtl/ctrl_decode_pipe.sv
// RV32I(+M) decode controller with a registered D->E control boundary.
// Multi-cycle MUL/DIV occupancy is tracked by a small busy FSM that stalls the front end.
module ctrl_decode_pipe #(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_d,
  input  logic [31:0] instr_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [3:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic [2:0]  ImmSrcE,
  output logic        SrcAsrcE,
  output logic        jumpRegE,
  output logic [2:0]  funct3E,
  output logic        mdE,
  output logic        illegalE,
  output logic        md_busy,
  output logic        md_done
);

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctl;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       src_a_pc;
    logic       jump_reg;
    logic [2:0] funct3;
    logic       md;
    logic       illegal;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_J = 3'b011, IMM_U = 3'b100;

  // alt selects SUB (funct3 000) or SRA (funct3 101); callers only set it where legal.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      dec;
  ctrl_t      e_q;

  assign opcode = instr_d[6:0];
  assign f3     = instr_d[14:12];
  assign f7     = instr_d[31:25];

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    dec        = '0;
    dec.funct3 = f3;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_ctl = alu_op(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.alu_ctl = alu_op(f3, 1'b1);
        end else if (ENABLE_M && f7 == 7'b0000001) begin
          dec.md         = 1'b1;
          dec.result_src = 2'b11;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_I;
        if (f3 == 3'b001) begin
          dec.alu_ctl = ALU_SLL;
          dec.illegal = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec.alu_ctl = alu_op(f3, f7 == 7'b0100000);
          dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end else begin
          // Bit 30 is immediate data here, never an opcode modifier.
          dec.alu_ctl = alu_op(f3, 1'b0);
        end
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_I;
        dec.illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
        dec.illegal   = (f3 > 3'b010);
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_ctl = ALU_SUB;
        dec.imm_src = IMM_B;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_J;
        dec.src_a_pc   = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jump_reg   = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_I;
        dec.illegal    = (f3 != 3'b000);
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_ctl   = ALU_PASSB;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
        dec.src_a_pc  = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An undecodable instruction must never cause an architectural side effect.
    if (dec.illegal) begin
      dec        = '0;
      dec.funct3 = f3;
      dec.illegal = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
    end else if (!md_busy && !stall_e) begin
      if (flush_e || !valid_d) e_q <= '0;
      else                     e_q <= dec;
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign ResultSrcE  = e_q.result_src;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUControlE = e_q.alu_ctl;
  assign ALUSrcE     = e_q.alu_src;
  assign ImmSrcE     = e_q.imm_src;
  assign SrcAsrcE    = e_q.src_a_pc;
  assign jumpRegE    = e_q.jump_reg;
  assign funct3E     = e_q.funct3;
  assign mdE         = e_q.md;
  assign illegalE    = e_q.illegal;

  generate
    if (ENABLE_M) begin : g_md
      typedef enum logic {IDLE, BUSY} md_state_t;

      localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
      localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

      md_state_t  state, state_nx;
      logic [5:0] count, count_nx;
      logic [5:0] n_sel;

      assign n_sel = e_q.funct3[2] ? DIV_N : MUL_N;

      always_ff @(posedge clk) begin
        if (reset) begin
          state <= IDLE;
          count <= '0;
        end else begin
          state <= state_nx;
          count <= count_nx;
        end
      end

      // The first E cycle of an M op is spent in IDLE, so BUSY covers the remaining N-1.
      always_comb begin
        state_nx = state;
        count_nx = count;
        md_busy  = 1'b0;
        md_done  = 1'b0;
        case (state)
          IDLE: begin
            if (e_q.md) begin
              if (n_sel == 6'd1) begin
                md_done = 1'b1;
              end else begin
                md_busy  = 1'b1;
                state_nx = BUSY;
                count_nx = n_sel - 6'd1;
              end
            end
          end
          default: begin
            count_nx = count - 6'd1;
            if (count == 6'd1) begin
              md_done  = 1'b1;
              state_nx = IDLE;
            end else begin
              md_busy = 1'b1;
            end
          end
        endcase
      end
    end else begin : g_no_md
      assign md_busy = 1'b0;
      assign md_done = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: expected bundles are queued as stimulus is driven
// and compared one cycle later when the E register presents them.
module tb_ctrl_decode_pipe;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       br;
    logic [3:0] alu;
    logic       asrc;
    logic [2:0] imm;
    logic       srca;
    logic       jr;
    logic [2:0] f3;
    logic       md;
    logic       ill;
    logic       busy;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, valid_d, stall_e, flush_e;
  logic [31:0] instr_d;

  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, SrcAsrcE, jumpRegE;
  logic        mdE, illegalE, md_busy, md_done;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  ImmSrcE, funct3E;

  logic        nm_rw, nm_mw, nm_j, nm_br, nm_asrc, nm_srca, nm_jr, nm_md, nm_ill, nm_busy, nm_done;
  logic [1:0]  nm_rs;
  logic [3:0]  nm_alu;
  logic [2:0]  nm_imm, nm_f3;

  int checks = 0;
  int errors = 0;

  exp_t  sb[$];
  string tq[$];

  ctrl_decode_pipe dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .instr_d(instr_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .ImmSrcE(ImmSrcE), .SrcAsrcE(SrcAsrcE), .jumpRegE(jumpRegE), .funct3E(funct3E),
    .mdE(mdE), .illegalE(illegalE), .md_busy(md_busy), .md_done(md_done)
  );

  ctrl_decode_pipe #(.ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .valid_d(valid_d), .instr_d(instr_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .RegWriteE(nm_rw), .ResultSrcE(nm_rs), .MemWriteE(nm_mw),
    .JumpE(nm_j), .BranchE(nm_br), .ALUControlE(nm_alu), .ALUSrcE(nm_asrc),
    .ImmSrcE(nm_imm), .SrcAsrcE(nm_srca), .jumpRegE(nm_jr), .funct3E(nm_f3),
    .mdE(nm_md), .illegalE(nm_ill), .md_busy(nm_busy), .md_done(nm_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t ex);
    chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(ex.rw));
    chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(ex.rs));
    chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(ex.mw));
    chk({tag, ".JumpE"},       32'(JumpE),       32'(ex.j));
    chk({tag, ".BranchE"},     32'(BranchE),     32'(ex.br));
    chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(ex.alu));
    chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(ex.asrc));
    chk({tag, ".ImmSrcE"},     32'(ImmSrcE),     32'(ex.imm));
    chk({tag, ".SrcAsrcE"},    32'(SrcAsrcE),    32'(ex.srca));
    chk({tag, ".jumpRegE"},    32'(jumpRegE),    32'(ex.jr));
    chk({tag, ".funct3E"},     32'(funct3E),     32'(ex.f3));
    chk({tag, ".mdE"},         32'(mdE),         32'(ex.md));
    chk({tag, ".illegalE"},    32'(illegalE),    32'(ex.ill));
    chk({tag, ".md_busy"},     32'(md_busy),     32'(ex.busy));
    chk({tag, ".md_done"},     32'(md_done),     32'(ex.done));
  endtask

  // Drive one cycle of inputs, queue what E must show after the edge, then pop and compare.
  task automatic cyc(input logic rst, input logic v, input logic [31:0] ins,
                     input logic st, input logic fl, input exp_t ex, input string tag);
    exp_t  e;
    string t;
    reset   = rst;
    valid_d = v;
    instr_d = ins;
    stall_e = st;
    flush_e = fl;
    sb.push_back(ex);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    t = tq.pop_front();
    compare(t, e);
  endtask

  localparam logic [31:0] I_ADD   = 32'h002081B3, I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SW    = 32'h0020A423, I_JALR = 32'h000280E7;
  localparam logic [31:0] I_LUI   = 32'h123400B7, I_SRAI = 32'h40315093;
  localparam logic [31:0] I_ADDI  = 32'h40000093, I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_BEQ   = 32'h00208463, I_BAD7F = 32'h0000007F;
  localparam logic [31:0] I_ECALL = 32'h00000073, I_BADF7 = 32'h202081B3;
  localparam logic [31:0] I_DIV   = 32'h0220C1B3, I_MUL  = 32'h022081B3;

  exp_t e0, e_add, e_sub, e_sw, e_jalr, e_lui, e_srai, e_addi, e_auipc, e_beq, e_ill;
  exp_t e_div_b, e_div_d, e_mul_b, e_mul_d;

  initial begin
    e0 = '0;
    e_add = '0;  e_add.rw = 1'b1;
    e_sub = e_add; e_sub.alu = 4'b0001;
    e_sw = '0;   e_sw.mw = 1'b1; e_sw.asrc = 1'b1; e_sw.imm = 3'b001; e_sw.f3 = 3'b010;
    e_jalr = '0; e_jalr.rw = 1'b1; e_jalr.rs = 2'b10; e_jalr.j = 1'b1;
    e_jalr.jr = 1'b1; e_jalr.asrc = 1'b1;
    e_lui = '0;  e_lui.rw = 1'b1; e_lui.alu = 4'b1010; e_lui.asrc = 1'b1; e_lui.imm = 3'b100;
    e_srai = '0; e_srai.rw = 1'b1; e_srai.alu = 4'b1001; e_srai.asrc = 1'b1; e_srai.f3 = 3'b101;
    e_addi = '0; e_addi.rw = 1'b1; e_addi.asrc = 1'b1;
    e_auipc = '0; e_auipc.rw = 1'b1; e_auipc.asrc = 1'b1; e_auipc.imm = 3'b100;
    e_auipc.srca = 1'b1; e_auipc.f3 = 3'b001;
    e_beq = '0;  e_beq.br = 1'b1; e_beq.alu = 4'b0001; e_beq.imm = 3'b010;
    e_ill = '0;  e_ill.ill = 1'b1;
    e_div_b = '0; e_div_b.rw = 1'b1; e_div_b.rs = 2'b11; e_div_b.md = 1'b1;
    e_div_b.f3 = 3'b100; e_div_b.busy = 1'b1;
    e_div_d = e_div_b; e_div_d.busy = 1'b0; e_div_d.done = 1'b1;
    e_mul_b = e_div_b; e_mul_b.f3 = 3'b000;
    e_mul_d = e_mul_b; e_mul_d.busy = 1'b0; e_mul_d.done = 1'b1;

    reset = 1'b1; valid_d = 1'b0; instr_d = '0; stall_e = 1'b0; flush_e = 1'b0;

    cyc(1, 1, I_ADD, 0, 0, e0, "reset0");
    cyc(1, 1, I_DIV, 0, 0, e0, "reset1");

    cyc(0, 1, I_ADD,   0, 0, e_add,   "add");
    cyc(0, 1, I_SUB,   0, 0, e_sub,   "sub");
    cyc(0, 1, I_SW,    0, 0, e_sw,    "sw");
    cyc(0, 1, I_JALR,  0, 0, e_jalr,  "jalr");
    cyc(0, 1, I_LUI,   1, 0, e_jalr,  "stall_hold");
    cyc(0, 1, I_LUI,   0, 0, e_lui,   "lui");
    cyc(0, 1, I_SRAI,  0, 0, e_srai,  "srai");
    cyc(0, 1, I_ADDI,  0, 0, e_addi,  "addi_bit30");
    cyc(0, 1, I_AUIPC, 0, 0, e_auipc, "auipc");
    cyc(0, 1, I_BEQ,   0, 0, e_beq,   "beq");
    cyc(0, 1, I_BEQ,   0, 1, e0,      "flush_beq");
    cyc(0, 1, I_BAD7F, 0, 0, e_ill,   "opcode_7f");
    cyc(0, 1, I_ECALL, 0, 0, e_ill,   "ecall");
    cyc(0, 1, I_BADF7, 0, 0, e_ill,   "bad_funct7");
    cyc(0, 0, I_ADD,   0, 0, e0,      "invalid");

    // DIV: busy on cycles 1..7, done on 8, next instruction on 9.
    cyc(0, 1, I_DIV, 0, 0, e_div_b, "div_c1");
    for (int i = 2; i <= 7; i++) cyc(0, 1, I_ADD, 0, 0, e_div_b, $sformatf("div_c%0d", i));
    cyc(0, 1, I_ADD, 0, 0, e_div_d, "div_c8");
    cyc(0, 1, I_ADD, 0, 0, e_add,   "after_div");

    // MUL with flush during BUSY; the M-less instance sees the same encoding as illegal.
    cyc(0, 1, I_MUL, 0, 0, e_mul_b, "mul_c1");
    chk("nm_mul.illegalE", 32'(nm_ill),  32'd1);
    chk("nm_mul.RegWriteE", 32'(nm_rw),  32'd0);
    chk("nm_mul.MemWriteE", 32'(nm_mw),  32'd0);
    chk("nm_mul.mdE",      32'(nm_md),   32'd0);
    chk("nm_mul.md_busy",  32'(nm_busy), 32'd0);
    chk("nm_mul.ResultSrcE", 32'(nm_rs), 32'd0);
    cyc(0, 1, I_ADD, 0, 1, e_mul_d, "mul_flush_c2");
    cyc(0, 0, I_ADD, 0, 0, e0,      "after_mul");

    // Reset on cycle 3 of a DIV, then a fresh DIV straight away.
    cyc(0, 1, I_DIV, 0, 0, e_div_b, "rdiv_c1");
    cyc(0, 1, I_ADD, 0, 0, e_div_b, "rdiv_c2");
    cyc(0, 1, I_ADD, 0, 0, e_div_b, "rdiv_c3");
    cyc(1, 1, I_ADD, 0, 0, e0,      "rdiv_reset");
    cyc(0, 1, I_DIV, 0, 0, e_div_b, "div2_c1");
    for (int i = 2; i <= 7; i++) cyc(0, 0, I_ADD, 0, 0, e_div_b, $sformatf("div2_c%0d", i));
    cyc(0, 0, I_ADD, 0, 0, e_div_d, "div2_c8");
    cyc(0, 0, I_ADD, 0, 0, e0,      "div2_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
